// File: rtl/ip_pkg.sv
// Shared IPv4 constants, drop reasons and receive FSM states.
// Also holds the ones-complement fold used by the checksum accumulator.
package ip_pkg;

   localparam logic [7:0]  IP_PROTO_UDP     = 8'd17;
   localparam logic [3:0]  IP_VERSION_4     = 4'd4;
   localparam logic [15:0] IP_HDR_MIN_BYTES = 16'd20;

   localparam logic [2:0] DROP_NONE    = 3'd0;
   localparam logic [2:0] DROP_VERSION = 3'd1;
   localparam logic [2:0] DROP_LENGTH  = 3'd2;
   localparam logic [2:0] DROP_PROTO   = 3'd3;
   localparam logic [2:0] DROP_DEST    = 3'd4;
   localparam logic [2:0] DROP_CSUM    = 3'd5;

   typedef enum logic [2:0] {
      HDR,
      OPT,
      PAY,
      PAD,
      DROP
   } state_t;

   // Two end-around carry folds: the first can itself produce a carry.
   function automatic logic [15:0] csum_fold(input logic [17:0] sum);
      logic [16:0] t;
      t = {1'b0, sum[15:0]} + {15'd0, sum[17:16]};
      return t[15:0] + {15'd0, t[16]};
   endfunction

endpackage

// File: rtl/ip_csum_acc.sv
// 16-bit ones-complement accumulator: clear, one word per strobe, folded result.
// o_fold already includes the word presented in the current cycle.
module ip_csum_acc
   import ip_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        i_clear,
   input  logic        i_word_vld,
   input  logic [15:0] i_word,
   output logic [15:0] o_fold
);

   logic [17:0] r_sum;
   logic [17:0] w_next;

   // Carries are folded back in every cycle so the 18-bit sum can never overflow.
   always_comb begin
      w_next = {2'b00, r_sum[15:0]} + {16'd0, r_sum[17:16]};
      if (i_word_vld) begin
         w_next = w_next + {2'b00, i_word};
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sum <= '0;
      end else if (i_clear) begin
         r_sum <= '0;
      end else if (i_word_vld) begin
         r_sum <= w_next;
      end
   end

   assign o_fold = csum_fold(w_next);

endmodule

// File: rtl/ip_rcv.sv
// IPv4 receive stage: parses and validates the header, skips options, and
// forwards only the payload of accepted packets through a single output register.
module ip_rcv
   import ip_pkg::*;
#(
   parameter logic [31:0] LOCAL_IP     = 32'hC0A8_0102,
   parameter bit          ACCEPT_BCAST = 1'b1,
   parameter bit          CHECK_CSUM   = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [7:0]  ip_axis_tdata_in,
   input  logic        ip_axis_tvalid_in,
   input  logic        ip_axis_tlast_in,
   output logic        ip_axis_tready_out,
   output logic [7:0]  udp_axis_tdata_out,
   output logic        udp_axis_tvalid_out,
   output logic        udp_axis_tlast_out,
   input  logic        udp_axis_tready_in,
   output logic [31:0] src_ip_out,
   output logic        drop_out,
   output logic [2:0]  drop_code_out,
   output logic        trunc_out
);

   state_t      r_state;
   logic [15:0] r_byte_cnt;
   logic [15:0] r_total_len;
   logic [3:0]  r_version;
   logic [3:0]  r_ihl;
   logic [7:0]  r_proto;
   logic [7:0]  r_hi_byte;
   logic [31:0] r_src_ip;
   logic [31:0] r_dst_ip;

   logic [7:0]  r_tdata;
   logic        r_tvalid;
   logic        r_tlast;
   logic [31:0] r_src_ip_out;
   logic        r_drop;
   logic [2:0]  r_drop_code;
   logic        r_trunc;

   logic        w_xfer;
   logic        w_in_hdr;
   logic [15:0] w_hdr_len;
   logic        w_last_hdr;
   logic        w_pay_last;
   logic [31:0] w_dst_eval;
   logic [15:0] w_csum_fold;
   logic        w_csum_clr;
   logic        w_word_vld;
   logic [2:0]  w_eval_code;

   assign ip_axis_tready_out = (r_state != PAY) || !r_tvalid || udp_axis_tready_in;

   assign w_xfer     = ip_axis_tvalid_in && ip_axis_tready_out;
   assign w_in_hdr   = (r_state == HDR) || (r_state == OPT);
   assign w_hdr_len  = {10'd0, r_ihl, 2'b00};
   assign w_pay_last = (r_byte_cnt == r_total_len - 16'd1);
   assign w_last_hdr = w_xfer &&
      (((r_state == HDR) && (r_byte_cnt == IP_HDR_MIN_BYTES - 16'd1) && (r_ihl <= 4'd5)) ||
       ((r_state == OPT) && (r_byte_cnt == w_hdr_len - 16'd1)));

   // The last destination byte is still on the bus when a plain header is evaluated.
   assign w_dst_eval = (r_state == HDR) ? {r_dst_ip[23:0], ip_axis_tdata_in} : r_dst_ip;

   assign w_csum_clr = w_xfer && (r_state == HDR) && (r_byte_cnt == 16'd0);
   assign w_word_vld = w_xfer && w_in_hdr && r_byte_cnt[0];

   ip_csum_acc u_csum (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_clear    (w_csum_clr),
      .i_word_vld (w_word_vld),
      .i_word     ({r_hi_byte, ip_axis_tdata_in}),
      .o_fold     (w_csum_fold)
   );

   always_comb begin
      w_eval_code = DROP_NONE;
      if (r_version != IP_VERSION_4) begin
         w_eval_code = DROP_VERSION;
      end else if ((r_ihl < 4'd5) || (r_total_len < w_hdr_len)) begin
         w_eval_code = DROP_LENGTH;
      end else if (r_proto != IP_PROTO_UDP) begin
         w_eval_code = DROP_PROTO;
      end else if ((w_dst_eval != LOCAL_IP) && !(ACCEPT_BCAST && (w_dst_eval == 32'hFFFF_FFFF))) begin
         w_eval_code = DROP_DEST;
      end else if (CHECK_CSUM && (w_csum_fold != 16'hFFFF)) begin
         w_eval_code = DROP_CSUM;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= HDR;
         r_byte_cnt   <= '0;
         r_total_len  <= '0;
         r_version    <= '0;
         r_ihl        <= '0;
         r_proto      <= '0;
         r_hi_byte    <= '0;
         r_src_ip     <= '0;
         r_dst_ip     <= '0;
         r_tdata      <= '0;
         r_tvalid     <= 1'b0;
         r_tlast      <= 1'b0;
         r_src_ip_out <= '0;
         r_drop       <= 1'b0;
         r_drop_code  <= '0;
         r_trunc      <= 1'b0;
      end else begin
         r_drop  <= 1'b0;
         r_trunc <= 1'b0;
         if (r_tvalid && udp_axis_tready_in) begin
            r_tvalid <= 1'b0;
         end

         if (w_xfer) begin
            r_byte_cnt <= ip_axis_tlast_in ? 16'd0 : r_byte_cnt + 16'd1;

            case (r_state)
               HDR, OPT: begin
                  if (r_state == HDR) begin
                     case (r_byte_cnt)
                        16'd0: begin
                           r_version <= ip_axis_tdata_in[7:4];
                           r_ihl     <= ip_axis_tdata_in[3:0];
                        end
                        16'd2:                         r_total_len[15:8] <= ip_axis_tdata_in;
                        16'd3:                         r_total_len[7:0]  <= ip_axis_tdata_in;
                        16'd9:                         r_proto           <= ip_axis_tdata_in;
                        16'd12, 16'd13, 16'd14, 16'd15: r_src_ip <= {r_src_ip[23:0], ip_axis_tdata_in};
                        16'd16, 16'd17, 16'd18, 16'd19: r_dst_ip <= {r_dst_ip[23:0], ip_axis_tdata_in};
                        default: ;
                     endcase
                  end
                  if (!r_byte_cnt[0]) begin
                     r_hi_byte <= ip_axis_tdata_in;
                  end

                  if (w_last_hdr) begin
                     if (w_eval_code != DROP_NONE) begin
                        r_drop      <= 1'b1;
                        r_drop_code <= w_eval_code;
                        r_state     <= ip_axis_tlast_in ? HDR : DROP;
                     end else if (ip_axis_tlast_in && (r_total_len != w_hdr_len)) begin
                        r_drop      <= 1'b1;
                        r_drop_code <= DROP_LENGTH;
                        r_state     <= HDR;
                     end else begin
                        r_src_ip_out <= r_src_ip;
                        if (ip_axis_tlast_in) begin
                           r_state <= HDR;
                        end else begin
                           r_state <= (r_total_len == w_hdr_len) ? PAD : PAY;
                        end
                     end
                  end else if (ip_axis_tlast_in) begin
                     r_drop      <= 1'b1;
                     r_drop_code <= DROP_LENGTH;
                     r_state     <= HDR;
                  end else if ((r_state == HDR) && (r_byte_cnt == IP_HDR_MIN_BYTES - 16'd1)) begin
                     r_state <= OPT;
                  end
               end

               PAY: begin
                  r_tdata  <= ip_axis_tdata_in;
                  r_tvalid <= 1'b1;
                  r_tlast  <= w_pay_last || ip_axis_tlast_in;
                  r_trunc  <= ip_axis_tlast_in && !w_pay_last;
                  if (ip_axis_tlast_in) begin
                     r_state <= HDR;
                  end else if (w_pay_last) begin
                     r_state <= PAD;
                  end
               end

               default: begin
                  if (ip_axis_tlast_in) begin
                     r_state <= HDR;
                  end
               end
            endcase
         end
      end
   end

   assign udp_axis_tdata_out  = r_tdata;
   assign udp_axis_tvalid_out = r_tvalid;
   assign udp_axis_tlast_out  = r_tlast;
   assign src_ip_out          = r_src_ip_out;
   assign drop_out            = r_drop;
   assign drop_code_out       = r_drop_code;
   assign trunc_out           = r_trunc;

endmodule

// File: tb/tb_ip_rcv.sv
// Directed bench for ip_rcv: builds IPv4 frames byte by byte and checks the
// forwarded payload, drop codes, truncation and reset behaviour.
module tb_ip_rcv;

   localparam logic [31:0] LOCAL = 32'hC0A8_0102;
   localparam logic [31:0] SRC_A = 32'hC0A8_010A;
   localparam logic [31:0] SRC_B = 32'h0A00_0005;
   localparam logic [31:0] SRC_C = 32'h0102_0304;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [7:0]  ip_tdata;
   logic        ip_tvalid;
   logic        ip_tlast;
   logic        ip_tready;
   logic [7:0]  udp_tdata;
   logic        udp_tvalid;
   logic        udp_tlast;
   logic        udp_tready;
   logic [31:0] src_ip;
   logic        drop;
   logic [2:0]  drop_code;
   logic        trunc;

   int checks   = 0;
   int failures = 0;

   logic [7:0] pkt[$];
   logic [7:0] pay[$];
   logic [7:0] tx_d[$];
   logic       tx_l[$];
   logic [7:0] out_d[$];
   logic       out_l[$];
   logic [7:0] exp_d[$];
   int         n_drop;
   int         n_trunc;
   int         n_stall;
   logic [2:0] last_code;
   logic       p_stall = 1'b0;
   logic [9:0] p_beat  = '0;

   ip_rcv #(
      .LOCAL_IP     (LOCAL),
      .ACCEPT_BCAST (1'b1),
      .CHECK_CSUM   (1'b1)
   ) dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .ip_axis_tdata_in    (ip_tdata),
      .ip_axis_tvalid_in   (ip_tvalid),
      .ip_axis_tlast_in    (ip_tlast),
      .ip_axis_tready_out  (ip_tready),
      .udp_axis_tdata_out  (udp_tdata),
      .udp_axis_tvalid_out (udp_tvalid),
      .udp_axis_tlast_out  (udp_tlast),
      .udp_axis_tready_in  (udp_tready),
      .src_ip_out          (src_ip),
      .drop_out            (drop),
      .drop_code_out       (drop_code),
      .trunc_out           (trunc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Output monitor: sampled mid-cycle, after the driver has set udp_tready for the next edge.
   always @(negedge clk) begin
      #2;
      if (reset_n) begin
         if (p_stall) check("beat_held_while_stalled", {54'd0, udp_tvalid, udp_tlast, udp_tdata}, {54'd0, p_beat});
         if (udp_tvalid && udp_tready) begin
            out_d.push_back(udp_tdata);
            out_l.push_back(udp_tlast);
         end
         if (drop) begin
            n_drop++;
            last_code = drop_code;
         end
         if (trunc) n_trunc++;
         p_stall = udp_tvalid && !udp_tready;
         p_beat  = {udp_tvalid, udp_tlast, udp_tdata};
      end else begin
         p_stall = 1'b0;
      end
   end

   task automatic build_pkt(input logic [3:0] ver, input logic [3:0] ihl, input logic [15:0] tot,
                            input logic [7:0] proto, input logic [31:0] src, input logic [31:0] dst,
                            input logic [15:0] csum_adj, input int pay_n, input int pad_n,
                            input logic [7:0] seed);
      int          hlen;
      logic [31:0] s;
      logic [15:0] c;
      pkt.delete();
      pay.delete();
      pkt.push_back({ver, ihl}); pkt.push_back(8'h00);
      pkt.push_back(tot[15:8]);  pkt.push_back(tot[7:0]);
      pkt.push_back(8'h12);      pkt.push_back(8'h34);
      pkt.push_back(8'h00);      pkt.push_back(8'h00);
      pkt.push_back(8'h40);      pkt.push_back(proto);
      pkt.push_back(8'h00);      pkt.push_back(8'h00);
      for (int k = 3; k >= 0; k--) pkt.push_back(src[k*8 +: 8]);
      for (int k = 3; k >= 0; k--) pkt.push_back(dst[k*8 +: 8]);
      hlen = (int'(ihl) > 5) ? int'(ihl) * 4 : 20;
      for (int k = 20; k < hlen; k++) pkt.push_back(8'h94 + 8'(k));
      s = 32'd0;
      for (int k = 0; k < hlen; k += 2) s = s + {16'd0, pkt[k], pkt[k+1]};
      while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
      c = ~s[15:0] + csum_adj;
      pkt[10] = c[15:8];
      pkt[11] = c[7:0];
      for (int k = 0; k < pay_n; k++) begin
         pkt.push_back(seed + 8'(k));
         pay.push_back(seed + 8'(k));
      end
      for (int k = 0; k < pad_n; k++) pkt.push_back(8'hEE);
   endtask

   task automatic queue_pkt(input bit with_last);
      foreach (pkt[k]) begin
         tx_d.push_back(pkt[k]);
         tx_l.push_back(with_last && (k == pkt.size() - 1));
      end
   endtask

   task automatic run_tx(input bit toggle, input int pay_lo, input int pay_hi);
      int i = 0;
      int budget = 0;
      while (i < tx_d.size() && budget < 4000) begin
         @(negedge clk);
         if (toggle) udp_tready = ~udp_tready;
         ip_tdata  = tx_d[i];
         ip_tvalid = 1'b1;
         ip_tlast  = tx_l[i];
         #1;
         if (toggle && i >= pay_lo && i <= pay_hi && udp_tvalid && !udp_tready) begin
            n_stall++;
            check("tready_low_while_stalled", {63'd0, ip_tready}, 64'd0);
         end
         if (ip_tready) i++;
         budget++;
      end
      check("tx_all_bytes_accepted", i, tx_d.size());
      @(negedge clk);
      ip_tvalid = 1'b0;
      ip_tlast  = 1'b0;
      ip_tdata  = 8'h00;
      tx_d.delete();
      tx_l.delete();
   endtask

   task automatic drain();
      udp_tready = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic clear_obs();
      out_d.delete();
      out_l.delete();
      exp_d.delete();
      n_drop    = 0;
      n_trunc   = 0;
      n_stall   = 0;
      last_code = 3'd0;
   endtask

   task automatic check_stream(input string tag, input int exp_lasts);
      int lasts = 0;
      check({tag, "_count"}, out_d.size(), exp_d.size());
      for (int k = 0; k < out_d.size() && k < exp_d.size(); k++) check({tag, "_byte"}, out_d[k], exp_d[k]);
      foreach (out_l[k]) if (out_l[k]) lasts++;
      check({tag, "_tlast_count"}, lasts, exp_lasts);
      if (exp_lasts > 0 && out_l.size() > 0) check({tag, "_tlast_on_final"}, {63'd0, out_l[out_l.size()-1]}, 64'd1);
   endtask

   task automatic run_drop(input string tag, input logic [2:0] code);
      clear_obs();
      queue_pkt(1'b1);
      run_tx(1'b0, 0, 0);
      drain();
      check_stream(tag, 0);
      check({tag, "_drops"}, n_drop, 1);
      check({tag, "_code"}, {61'd0, last_code}, {61'd0, code});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n    = 1'b0;
      ip_tdata   = 8'h00;
      ip_tvalid  = 1'b0;
      ip_tlast   = 1'b0;
      udp_tready = 1'b1;
      clear_obs();
      repeat (3) @(negedge clk);
      check("rst_tvalid", {63'd0, udp_tvalid}, 64'd0);
      check("rst_tlast",  {63'd0, udp_tlast},  64'd0);
      check("rst_tdata",  {56'd0, udp_tdata},  64'd0);
      check("rst_src_ip", {32'd0, src_ip},     64'd0);
      check("rst_drop",   {60'd0, drop, drop_code}, 64'd0);
      check("rst_trunc",  {63'd0, trunc},      64'd0);
      reset_n = 1'b1;
      #1;
      check("rst_tready", {63'd0, ip_tready}, 64'd1);

      // Plain UDP packet, 16 payload bytes.
      clear_obs();
      build_pkt(4'd4, 4'd5, 16'd36, 8'd17, SRC_A, LOCAL, 16'd0, 16, 0, 8'h30);
      foreach (pay[k]) exp_d.push_back(pay[k]);
      queue_pkt(1'b1);
      run_tx(1'b0, 0, 0);
      drain();
      check_stream("basic", 1);
      check("basic_src_ip", {32'd0, src_ip}, {32'd0, SRC_A});
      check("basic_drops", n_drop, 0);
      check("basic_trunc", n_trunc, 0);

      // Padded frame followed back-to-back by a second frame.
      clear_obs();
      build_pkt(4'd4, 4'd5, 16'd36, 8'd17, SRC_A, LOCAL, 16'd0, 16, 10, 8'h50);
      foreach (pay[k]) exp_d.push_back(pay[k]);
      queue_pkt(1'b1);
      build_pkt(4'd4, 4'd5, 16'd36, 8'd17, SRC_B, LOCAL, 16'd0, 16, 0, 8'h70);
      foreach (pay[k]) exp_d.push_back(pay[k]);
      queue_pkt(1'b1);
      run_tx(1'b0, 0, 0);
      drain();
      check_stream("pad_b2b", 2);
      check("pad_b2b_src_ip", {32'd0, src_ip}, {32'd0, SRC_B});
      check("pad_b2b_drops", n_drop, 0);

      // IHL=6: one option word skipped but checksummed.
      clear_obs();
      build_pkt(4'd4, 4'd6, 16'd40, 8'd17, SRC_A, LOCAL, 16'd0, 16, 0, 8'h90);
      foreach (pay[k]) exp_d.push_back(pay[k]);
      queue_pkt(1'b1);
      run_tx(1'b0, 0, 0);
      drain();
      check_stream("opts", 1);
      check("opts_src_ip", {32'd0, src_ip}, {32'd0, SRC_A});
      check("opts_drops", n_drop, 0);

      // Rejections; a rejected header must not disturb src_ip_out.
      build_pkt(4'd4, 4'd6, 16'd40, 8'd17, SRC_C, LOCAL, 16'd1, 16, 0, 8'h90);
      run_drop("bad_csum", 3'd5);
      check("bad_csum_src_kept", {32'd0, src_ip}, {32'd0, SRC_A});
      build_pkt(4'd4, 4'd5, 16'd36, 8'd6, SRC_A, LOCAL, 16'd0, 16, 0, 8'h10);
      run_drop("proto_tcp", 3'd3);
      build_pkt(4'd4, 4'd5, 16'd36, 8'd17, SRC_A, 32'hC0A8_0109, 16'd0, 16, 0, 8'h10);
      run_drop("dst_other", 3'd4);
      build_pkt(4'd6, 4'd5, 16'd36, 8'd17, SRC_A, LOCAL, 16'd0, 16, 0, 8'h10);
      run_drop("version6", 3'd1);
      build_pkt(4'd4, 4'd4, 16'd36, 8'd17, SRC_A, LOCAL, 16'd0, 16, 0, 8'h10);
      run_drop("ihl4", 3'd2);
      build_pkt(4'd4, 4'd5, 16'd36, 8'd17, SRC_A, LOCAL, 16'd0, 16, 0, 8'h10);
      pkt = pkt[0:11];
      run_drop("hdr_early_tlast", 3'd2);

      // Broadcast destination is accepted.
      clear_obs();
      build_pkt(4'd4, 4'd5, 16'd36, 8'd17, SRC_B, 32'hFFFF_FFFF, 16'd0, 16, 0, 8'hC0);
      foreach (pay[k]) exp_d.push_back(pay[k]);
      queue_pkt(1'b1);
      run_tx(1'b0, 0, 0);
      drain();
      check_stream("bcast", 1);
      check("bcast_src_ip", {32'd0, src_ip}, {32'd0, SRC_B});
      check("bcast_drops", n_drop, 0);

      // Downstream ready toggling every cycle during the frame.
      clear_obs();
      build_pkt(4'd4, 4'd5, 16'd36, 8'd17, SRC_A, LOCAL, 16'd0, 16, 0, 8'h30);
      foreach (pay[k]) exp_d.push_back(pay[k]);
      queue_pkt(1'b1);
      run_tx(1'b1, 20, 35);
      drain();
      check_stream("bp", 1);
      check("bp_stalls_seen", {63'd0, n_stall > 0}, 64'd1);
      check("bp_drops", n_drop, 0);

      // Input tlast after 10 of 16 payload bytes.
      clear_obs();
      build_pkt(4'd4, 4'd5, 16'd36, 8'd17, SRC_A, LOCAL, 16'd0, 10, 0, 8'h60);
      foreach (pay[k]) exp_d.push_back(pay[k]);
      queue_pkt(1'b1);
      run_tx(1'b0, 0, 0);
      drain();
      check_stream("trunc", 1);
      check("trunc_pulses", n_trunc, 1);
      check("trunc_drops", n_drop, 0);

      // Reset while a payload beat is pending, then a clean packet.
      clear_obs();
      build_pkt(4'd4, 4'd5, 16'd36, 8'd17, SRC_A, LOCAL, 16'd0, 16, 0, 8'h30);
      pkt = pkt[0:24];
      queue_pkt(1'b0);
      run_tx(1'b0, 0, 0);
      #1;
      check("midrst_beat_pending", {63'd0, udp_tvalid}, 64'd1);
      reset_n = 1'b0;
      #1;
      check("midrst_tvalid", {63'd0, udp_tvalid}, 64'd0);
      check("midrst_tdata",  {56'd0, udp_tdata},  64'd0);
      check("midrst_src_ip", {32'd0, src_ip},     64'd0);
      check("midrst_tready", {63'd0, ip_tready},  64'd1);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      clear_obs();
      build_pkt(4'd4, 4'd5, 16'd36, 8'd17, SRC_B, LOCAL, 16'd0, 16, 0, 8'hA0);
      foreach (pay[k]) exp_d.push_back(pay[k]);
      queue_pkt(1'b1);
      run_tx(1'b0, 0, 0);
      drain();
      check_stream("after_rst", 1);
      check("after_rst_src_ip", {32'd0, src_ip}, {32'd0, SRC_B});
      check("after_rst_drops", n_drop, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ip_rcv.md
Name: ip_rcv

Overview:
- Receive-side IPv4 stage directly upstream of the UDP receiver. Consumes the byte stream left after the Ethernet MAC header is stripped, parses and validates the IPv4 header, and skips options.
- Forwards only the IP payload (the UDP datagram) of accepted packets, with tlast on the last payload byte. Ethernet padding beyond the IP total length is discarded.
- Exposes the source IP address of the packet being forwarded, plus a drop-reason pulse.

Parameters:
- LOCAL_IP, 32'hC0A8_0102, unicast destination address accepted (192.168.1.2).
- ACCEPT_BCAST, 1, also accept destination 32'hFFFF_FFFF.
- CHECK_CSUM, 1, verify the header checksum; 0 skips the check.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- ip_axis_tdata_in  in  8  byte stream, first byte = IPv4 version/IHL.
- ip_axis_tvalid_in  in  1  input byte valid.
- ip_axis_tlast_in  in  1  last byte of frame (may include padding).
- ip_axis_tready_out  out  1  input accept.
- udp_axis_tdata_out  out  8  payload byte.
- udp_axis_tvalid_out  out  1  payload valid.
- udp_axis_tlast_out  out  1  last payload byte.
- udp_axis_tready_in  in  1  downstream accept.
- src_ip_out  out  32  source IP, stable from first payload byte to the next accepted header.
- drop_out  out  1  one-cycle pulse when a packet is rejected.
- drop_code_out  out  3  reason, valid with drop_out: 1 version, 2 IHL/length, 3 protocol, 4 dest IP, 5 checksum.
- trunc_out  out  1  one-cycle pulse: input tlast arrived before the IP total length was reached.

Behaviour:
- Reset (async assert, sync release) state:
  - FSM in HDR; counters 0.
  - All outputs 0; ip_axis_tready_out is 1 immediately after reset.
- Input transfer: a byte transfers when ip_axis_tvalid_in && ip_axis_tready_out.
- Input ready:
  - ip_axis_tready_out = 1 in HDR, OPT, PAD and DROP.
  - In PAY it is (!udp_axis_tvalid_out || udp_axis_tready_in).
- Output register: a single output register. tvalid is held until tready; data, tlast and valid do not change while the transfer is stalled.
- byte_cnt: 16 bits, counts transferred bytes from the frame start and is reset to 0 in every state on an input tlast.
- HDR state (bytes 0..19):
  - Capture: byte0 → version = [7:4], IHL = [3:0].
  - Capture: bytes 2-3 → total_len; byte 9 → protocol; bytes 12-15 → src_ip; bytes 16-19 → dst_ip.
  - Checksum: ones-complement accumulate of 16-bit big-endian words into an 18-bit sum; fold the end-around carry before the compare.
  - After byte 19: if IHL > 5, go to OPT; else evaluate.
- OPT state: bytes 20..IHL*4-1 are skipped but added to the checksum. Evaluate after the last option byte.
- Evaluation (single cycle; the first check that fails sets the drop code):
  - version != 4 → code 1.
  - IHL < 5, or total_len < IHL*4 → code 2.
  - protocol != 17 → code 3.
  - dst_ip != LOCAL_IP and not (ACCEPT_BCAST and dst == all-ones) → code 4.
  - CHECK_CSUM and folded sum != 16'hFFFF → code 5.
  - On failure: drop_out pulses, go to DROP.
  - On pass: src_ip_out is updated, go to PAY. If total_len == IHL*4, go to PAD instead and emit nothing.
- PAY state:
  - Each accepted byte is copied to the output register.
  - tlast_out = 1 when byte_cnt == total_len-1, then go to PAD. If the input tlast coincides with that byte, go to HDR.
  - If an input tlast arrives earlier: tlast_out = 1 on that byte, trunc_out pulses, go to HDR.
- PAD / DROP states: consume bytes with no output; on input tlast, go to HDR.
- Early tlast in HDR/OPT: the frame is discarded, drop_out pulses with code 2, go to HDR.
- Back-to-back frames: the HDR of frame N+1 may start the cycle after the tlast of frame N. No bubble is required.
- Reset mid-frame: everything clears at once, including an output beat that is still pending (valid drops to 0). The remainder of the interrupted frame is parsed as a header and will almost certainly be dropped.

Decomposition:
- Shared package ip_pkg:
  - Constants IP_PROTO_UDP = 8'd17, IP_VERSION_4 = 4'd4, IP_HDR_MIN_BYTES = 20.
  - Drop-code constants 1..5.
  - State enum {HDR, OPT, PAY, PAD, DROP}.
- Sub-module ip_csum_acc (16-bit ones-complement accumulator with clear, byte-pair strobe and fold output). It is reusable by a future ip_send.

Test Plan:
- Valid UDP packet: IHL=5, total_len=36 (16 payload bytes), dst 192.168.1.2, correct checksum, udp_tready_in=1 → 16 bytes out, tlast on byte 16, src_ip_out = the header source, no drop_out.
- Same packet with 10 bytes of Ethernet padding before tlast → still exactly 16 bytes out. Then a second packet starts the next cycle and is forwarded intact.
- IHL=6 (4 option bytes) with a correct checksum → options are skipped and the payload is forwarded. The same packet with a checksum field off by 1 → no output, drop_out with code 5.
- protocol=6 → code 3. dst 192.168.1.9 → code 4. dst FF.FF.FF.FF with ACCEPT_BCAST=1 → forwarded.
- udp_tready_in toggled 1/0 every cycle during the payload → the output byte sequence is identical and ip_axis_tready_out is deasserted while a beat is stalled.
- total_len=36 but input tlast after payload byte 10 → 10 bytes out with tlast on byte 10 and a trunc_out pulse. A reset_n pulse mid-payload → outputs go to 0 immediately, and the next full packet is forwarded correctly.
